// File: rtl/pwm_audio_out.sv
// pwm_audio_out: PCM sample stream to 1-bit PWM with a one-entry holding buffer and underrun flag
module pwm_audio_out #(
   parameter int DATA_W = 8,
   parameter int REPEAT = 4
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic [DATA_W-1:0] sample_data,
   input  logic              sample_valid,
   output logic              sample_ready,
   output logic              pwm_out,
   output logic              sample_tick,
   output logic              underrun
);
   localparam int REP_W = REPEAT > 1 ? $clog2(REPEAT) : 1;
   localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT - 1);
   logic [DATA_W-1:0] cnt, duty, sample_buf;
   logic [REP_W-1:0]  rep;
   logic              buf_full, boundary;
   assign sample_ready = !buf_full;
   assign boundary     = (cnt == '1) && (rep == REP_MAX);
   // frame/repeat counters, registered PWM compare and boundary pulses
   always_ff @(posedge sysclk) begin
      if (reset) begin
         cnt         <= '0;
         rep         <= '0;
         pwm_out     <= 1'b0;
         sample_tick <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         cnt         <= cnt + 1'b1;
         rep         <= (cnt == '1) ? ((rep == REP_MAX) ? '0 : rep + 1'b1) : rep;
         pwm_out     <= cnt < duty;
         sample_tick <= boundary;
         underrun    <= boundary && !buf_full;
      end
   end
   // holding buffer: accept when empty, hand over to duty on the boundary; reset parks duty at midscale
   always_ff @(posedge sysclk) begin
      if (reset) begin
         duty       <= {1'b1, {(DATA_W-1){1'b0}}};
         sample_buf <= '0;
         buf_full   <= 1'b0;
      end else if (boundary && buf_full) begin
         duty     <= sample_buf;
         buf_full <= 1'b0;
      end else if (sample_valid && !buf_full) begin
         sample_buf <= sample_data;
         buf_full   <= 1'b1;
      end
   end
endmodule

// File: tb/tb_pwm_audio_out.sv
// tb_pwm_audio_out: directed checks of PWM duty, buffering, underrun and reset for two REPEAT settings
module tb_pwm_audio_out;
   logic       sysclk, reset;
   logic [7:0] sample_data, r1_data;
   logic       sample_valid, sample_ready, pwm_out, sample_tick, underrun;
   logic       r1_valid, r1_ready, r1_pwm, r1_tick, r1_ur;
   logic       inc_mode;
   logic [7:0] pend[$];
   int         n_chk, n_fail;

   pwm_audio_out #(.DATA_W(8), .REPEAT(4)) u_dut (
      .sysclk(sysclk), .reset(reset), .sample_data(sample_data), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .pwm_out(pwm_out), .sample_tick(sample_tick), .underrun(underrun));

   pwm_audio_out #(.DATA_W(8), .REPEAT(1)) u_r1 (
      .sysclk(sysclk), .reset(reset), .sample_data(r1_data), .sample_valid(r1_valid),
      .sample_ready(r1_ready), .pwm_out(r1_pwm), .sample_tick(r1_tick), .underrun(r1_ur));

   initial sysclk = 1'b0;
   always #10 sysclk = ~sysclk;

   // runs n clocks from a negedge; feeds the next value on each accept
   task automatic measure(input int n, output int hi, output int tk, output int ur, output int acc, output int rdy);
      logic a;
      hi = 0; tk = 0; ur = 0; acc = 0; rdy = 0;
      for (int i = 0; i < n; i++) begin
         a = sample_valid && sample_ready;
         acc += int'(a);
         @(negedge sysclk);
         hi += int'(pwm_out); tk += int'(sample_tick); ur += int'(underrun); rdy += int'(sample_ready);
         if (a) begin
            if (inc_mode) sample_data = sample_data + 8'd1;
            else if (pend.size() > 0) sample_data = pend.pop_front();
            else sample_valid = 1'b0;
         end
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) @(negedge sysclk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      int hi, tk, ur, acc, rdy;
      reset = 1'b1;
      repeat (2) @(negedge sysclk);
      n_chk++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
      n_chk++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", sample_ready); end
      n_chk++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
      n_chk++; if (sample_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", sample_tick); end
      reset = 1'b0;
      for (int f = 0; f < 4; f++) begin
         measure(256, hi, tk, ur, acc, rdy);
         n_chk++; if (hi !== 128) begin n_fail++; $display("FAIL idle_frame%0d_high: got %0d want 128", f, hi); end
         n_chk++; if (ur !== (f == 3 ? 1 : 0)) begin n_fail++; $display("FAIL idle_frame%0d_underrun: got %0d want %0d", f, ur, f == 3 ? 1 : 0); end
         n_chk++; if (tk !== (f == 3 ? 1 : 0)) begin n_fail++; $display("FAIL idle_frame%0d_tick: got %0d want %0d", f, tk, f == 3 ? 1 : 0); end
      end
      measure(1023, hi, tk, ur, acc, rdy);
      n_chk++; if (ur !== 0) begin n_fail++; $display("FAIL idle_pre_boundary_underrun: got %0d want 0", ur); end
      measure(1, hi, tk, ur, acc, rdy);
      n_chk++; if (ur !== 1) begin n_fail++; $display("FAIL idle_boundary_underrun: got %0d want 1", ur); end
   endtask

   task automatic test_single();
      int hi, tk, ur, acc, rdy;
      do_reset(2);
      sample_data = 8'h40; sample_valid = 1'b1;
      measure(1024, hi, tk, ur, acc, rdy);
      n_chk++; if (acc !== 1) begin n_fail++; $display("FAIL single_accepts: got %0d want 1", acc); end
      n_chk++; if (rdy !== 1) begin n_fail++; $display("FAIL single_ready_cycles: got %0d want 1", rdy); end
      n_chk++; if (ur !== 0) begin n_fail++; $display("FAIL single_first_boundary_underrun: got %0d want 0", ur); end
      n_chk++; if (hi !== 512) begin n_fail++; $display("FAIL single_pre_load_high: got %0d want 512", hi); end
      for (int f = 0; f < 4; f++) begin
         measure(256, hi, tk, ur, acc, rdy);
         n_chk++; if (hi !== 64) begin n_fail++; $display("FAIL single_frame%0d_high: got %0d want 64", f, hi); end
      end
      n_chk++; if (ur !== 1) begin n_fail++; $display("FAIL single_second_boundary_underrun: got %0d want 1", ur); end
      measure(1024, hi, tk, ur, acc, rdy);
      n_chk++; if (hi !== 256) begin n_fail++; $display("FAIL single_repeat_high: got %0d want 256", hi); end
      n_chk++; if (ur !== 1) begin n_fail++; $display("FAIL single_repeat_underrun: got %0d want 1", ur); end
   endtask

   task automatic test_extremes();
      int hi, tk, ur, acc, rdy;
      do_reset(2);
      sample_data = 8'h00; sample_valid = 1'b1; pend.push_back(8'hFF);
      measure(1024, hi, tk, ur, acc, rdy);
      for (int f = 0; f < 4; f++) begin
         measure(256, hi, tk, ur, acc, rdy);
         n_chk++; if (hi !== 0) begin n_fail++; $display("FAIL zero_frame%0d_high: got %0d want 0", f, hi); end
      end
      n_chk++; if (ur !== 0) begin n_fail++; $display("FAIL zero_boundary_underrun: got %0d want 0", ur); end
      for (int f = 0; f < 4; f++) begin
         measure(256, hi, tk, ur, acc, rdy);
         n_chk++; if (hi !== 255) begin n_fail++; $display("FAIL full_frame%0d_high: got %0d want 255", f, hi); end
      end
      n_chk++; if (ur !== 1) begin n_fail++; $display("FAIL full_boundary_underrun: got %0d want 1", ur); end
   endtask

   task automatic test_back_to_back();
      int hi, tk, ur, acc, rdy;
      do_reset(2);
      inc_mode = 1'b1; sample_data = 8'h10; sample_valid = 1'b1;
      measure(1024, hi, tk, ur, acc, rdy);
      n_chk++; if (acc !== 1) begin n_fail++; $display("FAIL b2b_period0_accepts: got %0d want 1", acc); end
      for (int p = 1; p <= 4; p++) begin
         measure(1024, hi, tk, ur, acc, rdy);
         n_chk++; if (hi !== 4 * (16 + p - 1)) begin n_fail++; $display("FAIL b2b_period%0d_high: got %0d want %0d", p, hi, 4 * (16 + p - 1)); end
         n_chk++; if (acc !== 1) begin n_fail++; $display("FAIL b2b_period%0d_accepts: got %0d want 1", p, acc); end
         n_chk++; if (ur !== 0) begin n_fail++; $display("FAIL b2b_period%0d_underrun: got %0d want 0", p, ur); end
      end
      inc_mode = 1'b0; sample_valid = 1'b0;
   endtask

   task automatic test_mid_reset();
      int hi, tk, ur, acc, rdy;
      do_reset(2);
      sample_data = 8'h20; sample_valid = 1'b1;
      measure(1024, hi, tk, ur, acc, rdy);
      sample_data = 8'h55; sample_valid = 1'b1;
      measure(300, hi, tk, ur, acc, rdy);
      n_chk++; if (hi !== 64) begin n_fail++; $display("FAIL mid_duty20_high: got %0d want 64", hi); end
      n_chk++; if (sample_ready !== 1'b0) begin n_fail++; $display("FAIL mid_buffered_ready: got %b want 0", sample_ready); end
      do_reset(3);
      n_chk++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL mid_discard_ready: got %b want 1", sample_ready); end
      measure(128, hi, tk, ur, acc, rdy);
      n_chk++; if (hi !== 128) begin n_fail++; $display("FAIL mid_first_half_high: got %0d want 128", hi); end
      measure(128, hi, tk, ur, acc, rdy);
      n_chk++; if (hi !== 0) begin n_fail++; $display("FAIL mid_second_half_high: got %0d want 0", hi); end
      measure(768, hi, tk, ur, acc, rdy);
      n_chk++; if (hi !== 384) begin n_fail++; $display("FAIL mid_rest_high: got %0d want 384", hi); end
      n_chk++; if (tk !== 1) begin n_fail++; $display("FAIL mid_tick: got %0d want 1", tk); end
      n_chk++; if (ur !== 1) begin n_fail++; $display("FAIL mid_underrun: got %0d want 1", ur); end
   endtask

   task automatic test_repeat1();
      int h0, h1, ticks, ur, t0, t1;
      logic a;
      h0 = 0; h1 = 0; ticks = 0; ur = 0; t0 = -1; t1 = -1;
      do_reset(2);
      r1_data = 8'hC0; r1_valid = 1'b1;
      for (int i = 0; i < 512; i++) begin
         a = r1_valid && r1_ready;
         @(negedge sysclk);
         if (i < 256) h0 += int'(r1_pwm); else h1 += int'(r1_pwm);
         if (r1_tick) begin
            if (ticks == 0) t0 = i; else t1 = i;
            ticks++;
         end
         ur += int'(r1_ur);
         if (a) r1_valid = 1'b0;
      end
      n_chk++; if (h0 !== 128) begin n_fail++; $display("FAIL r1_first_frame_high: got %0d want 128", h0); end
      n_chk++; if (h1 !== 192) begin n_fail++; $display("FAIL r1_second_frame_high: got %0d want 192", h1); end
      n_chk++; if (ticks !== 2) begin n_fail++; $display("FAIL r1_ticks: got %0d want 2", ticks); end
      n_chk++; if (t0 !== 255) begin n_fail++; $display("FAIL r1_tick0_pos: got %0d want 255", t0); end
      n_chk++; if (t1 !== 511) begin n_fail++; $display("FAIL r1_tick1_pos: got %0d want 511", t1); end
      n_chk++; if (ur !== 1) begin n_fail++; $display("FAIL r1_underrun: got %0d want 1", ur); end
   endtask

   initial begin
      n_chk = 0; n_fail = 0; inc_mode = 1'b0;
      reset = 1'b1; sample_valid = 1'b0; sample_data = 8'h00; r1_valid = 1'b0; r1_data = 8'h00;
      test_reset();
      test_single();
      test_extremes();
      test_back_to_back();
      test_mid_reset();
      test_repeat1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pwm_audio_out.md
# pwm_audio_out

Audio PWM output stage that converts a stream of unsigned PCM samples into a 1-bit pulse-width-modulated signal suitable for the board's `pwm_aud` pins. It sits directly downstream of the tone/sample generators inside `top_top`. It accepts samples over a valid/ready handshake into a one-entry holding buffer and plays each sample for a fixed number of PWM frames. It repeats the last sample and flags underrun when the upstream source falls behind.

## Interface
- `DATA_W`, 8: sample width in bits. The PWM frame length is 2^DATA_W clocks.
- `REPEAT`, 4: PWM frames per sample, ≥1. The default gives 50 MHz/(256·4) ≈ 48.8 kHz.
- `sysclk`  in  1  system clock, 50 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `sample_data`  in  DATA_W  unsigned sample, midscale = silence.
- `sample_valid`  in  1  upstream has a sample on `sample_data`.
- `sample_ready`  out  1  holding buffer empty; a sample is accepted this cycle if `sample_valid` is high.
- `pwm_out`  out  1  registered PWM output.
- `sample_tick`  out  1  one-cycle pulse on every sample boundary.
- `underrun`  out  1  one-cycle pulse on a sample boundary when no sample was buffered.

## Operation
**Counters**
- `cnt` (DATA_W bits) increments every clock and wraps from 2^DATA_W−1 to 0.
- `rep` (range 0..REPEAT−1) increments when `cnt` wraps, and itself wraps to 0.

**Sample boundary**
- A sample boundary is the cycle where `cnt` = max and `rep` = REPEAT−1.

**Holding buffer**
- The buffer consists of `buf` and `buf_full`.
- `sample_ready` = !`buf_full`, driven combinationally from the register.
- On `sample_valid` && `sample_ready`: `buf` ← `sample_data`, `buf_full` ← 1.
- `sample_data` is ignored when no transfer occurs.

**At the sample boundary**
- If `buf_full`: `duty` ← `buf` and `buf_full` ← 0.
- Otherwise `duty` is held and `underrun` pulses.
- `sample_tick` pulses on every boundary.

**PWM compare**
- `pwm_out` ← (`cnt` < `duty`).
- `duty` = 0 gives a constant low output.
- `duty` = 2^DATA_W−1 gives high for 255 of 256 clocks; 100 % duty is not reachable.
- Compare is unsigned and DATA_W wide. There is no extension and no dithering.

**No accept on the boundary cycle**
- The buffer is full on a boundary only if `sample_ready` = 0, so a transfer and a load never collide.
- `sample_ready` rises the cycle after the boundary load.

**Reset**
- Reset has priority over all other activity, including mid-frame and mid-handshake. Any buffered sample is discarded.
- Register values after reset: `cnt` = 0, `rep` = 0, `duty` = 2^(DATA_W−1) (midscale, avoids a pop), `buf_full` = 0.

## Timing
**Output values during reset**
- `pwm_out` = 0, `sample_tick` = 0, `underrun` = 0.
- `sample_ready` = 1, since `buf_full` = 0.

**Counting after reset**
- The first clock after reset is deasserted sees `cnt` = 0.
- The first boundary occurs 2^DATA_W·REPEAT clocks later: cycle 1023 for the defaults.

**PWM latency**
- `pwm_out` lags the compare by one cycle.
- For a frame starting at `cnt` = 0 in cycle t, `pwm_out` is high during cycles t+1 … t+`duty`.

**Sample latency**
- A new `duty` takes effect with the `cnt` = 0 cycle after the boundary.
- Its PWM appears on `pwm_out` one cycle after that.
- The worst case from accept to output is 2^DATA_W·REPEAT+1 clocks.

**Throughput**
- At most one sample is accepted per sample period, plus one buffered sample.
- `sample_ready` stays low from the accept until the cycle after the next boundary.

**Pulse width**
- `sample_tick` and `underrun` are registered pulses, asserted in the cycle after the boundary, exactly 1 cycle wide.

## Test plan
Defaults: DATA_W = 8, REPEAT = 4.

- **Reset values:** hold `reset` for 2 cycles → `pwm_out` = 0, `sample_ready` = 1, `underrun` = 0. With no samples sent, each frame has `pwm_out` high for exactly 128 of 256 clocks, and `underrun` pulses every 1024 clocks.
- **Single sample:** send 0x40 once → `sample_ready` is low until the first boundary. The next 4 frames are 64/256 high, with no underrun at that boundary. An underrun pulse follows at the next boundary and the output stays at 64/256.
- **Duty extremes:** send 0x00, then 0xFF → 4 frames constantly low, then 4 frames with 255 high and 1 low per frame.
- **Back-pressure:** hold `sample_valid` high with an incrementing value (0x10, 0x11, …) → exactly one accept per 1024 clocks, and no underrun after the first load. Each 4-frame group plays the next value in order, with no value skipped or duplicated.
- **Mid-operation reset:** assert `reset` mid-frame while a sample is buffered and `duty` = 0x20 → after release, `duty` = 0x80, `cnt` restarts at 0, and the buffered sample is discarded (`sample_ready` = 1).
- **REPEAT = 1 variant:** send 0xC0 → every boundary is 256 clocks apart, and the output shows 192/256 duty for one frame.
